// File: rtl/regfile_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// regfile_ctrl_pkg
// Shared definitions for the register-file execute controller:
//   - default operand / select widths
//   - opcode encoding and FSM state encoding
//   - instruction field bit positions and the instruction width derivation
// Instruction layout (defaults): op[12:10] dst[9:8] a[7:6] b[5:4] imm[3:0]
// ---------------------------------------------------------------------------
package regfile_ctrl_pkg;

   localparam int DEF_DATA_W = 4;
   localparam int DEF_SEL_W  = 2;
   localparam int OP_W       = 3;
   localparam int IMM_LSB    = 0;

   typedef enum logic [OP_W-1:0] {
      OP_NOP = 3'd0,
      OP_LDI = 3'd1,
      OP_ADD = 3'd2,
      OP_SUB = 3'd3,
      OP_AND = 3'd4,
      OP_OR  = 3'd5,
      OP_XOR = 3'd6,
      OP_MUL = 3'd7
   } opcode_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MUL    = 3'd3,
      ST_WRITE  = 3'd4
   } state_e;

   // Instruction width: opcode, three register selects and the immediate.
   function automatic int instr_w(input int data_w, input int sel_w);
      return OP_W + 3 * sel_w + data_w;
   endfunction

   // Field LSB positions, packed upward from the immediate.
   function automatic int b_lsb(input int data_w);
      return data_w;
   endfunction

   function automatic int a_lsb(input int data_w, input int sel_w);
      return data_w + sel_w;
   endfunction

   function automatic int dst_lsb(input int data_w, input int sel_w);
      return data_w + 2 * sel_w;
   endfunction

   function automatic int op_lsb(input int data_w, input int sel_w);
      return data_w + 3 * sel_w;
   endfunction

endpackage

// File: rtl/shift_add_mul.sv
// ---------------------------------------------------------------------------
// shift_add_mul
// Iterative DATA_W x DATA_W unsigned shift-add multiplier, one multiplier
// bit per clock. A start pulse captures the operands; DATA_W busy cycles
// follow. done_o is high during the final busy cycle, and product_o already
// includes that cycle's partial product, so the caller can commit the full
// product on the same edge that ends the multiply.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start_i      capture a_i/b_i and begin
//   a_i, b_i     multiplicand / multiplier
//   busy_o       iteration in progress
//   done_o       last iteration in progress (product_o final)
//   product_o    2*DATA_W-bit product
// ---------------------------------------------------------------------------
module shift_add_mul #(
   parameter int DATA_W = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_i,
   input  logic [DATA_W-1:0]   a_i,
   input  logic [DATA_W-1:0]   b_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [2*DATA_W-1:0] product_o
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [2*DATA_W-1:0] mcand_q;
   logic [DATA_W-1:0]   mplier_q;
   logic [2*DATA_W-1:0] acc_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                busy_q;
   logic [2*DATA_W-1:0] step_acc;
   logic                last_step;

   assign step_acc  = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign last_step = busy_q && (cnt_q == CNT_W'(DATA_W - 1));

   // Operand capture on start, then one shift-add step per cycle while busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else if (start_i) begin
         mcand_q  <= {{DATA_W{1'b0}}, a_i};
         mplier_q <= b_i;
         acc_q    <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b1;
      end else if (busy_q) begin
         acc_q    <= step_acc;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q + CNT_W'(1);
         if (last_step) begin
            busy_q <= 1'b0;
         end
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = last_step;
   assign product_o = busy_q ? step_acc : acc_q;

endmodule

// File: rtl/regfile_exec_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_exec_ctrl
// Multi-cycle execute controller in front of a 4-entry register file with
// two combinational read ports and an enable-gated synchronous write port.
// Accepts one instruction per valid/ready handshake, drives the file's
// selects from the latched instruction, computes the result and writes it
// back, and keeps Z/C flags for a later branch stage.
// FSM: IDLE -> DECODE -> EXEC -> [MUL x DATA_W] -> WRITE -> IDLE
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   instr_valid / instr_ready  instruction handshake
//   instr                      op | dst | a | b | imm
//   rf_a, rf_b                 register file read data
//   rf_a_sel, rf_b_sel         register file read selects
//   rf_dest_sel, rf_d          write-back select / data
//   rf_load_en                 write strobe (WRITE state only)
//   done                       instruction-complete pulse
//   flag_z, flag_c             zero / carry-borrow-overflow flags
// Build option: define REGFILE_CTRL_SAT_EN for saturating ADD/SUB/MUL;
// otherwise arithmetic wraps modulo 2^DATA_W.
// ---------------------------------------------------------------------------
module regfile_exec_ctrl
   import regfile_ctrl_pkg::*;
#(
   parameter int  DATA_W  = DEF_DATA_W,
   parameter int  SEL_W   = DEF_SEL_W,
   localparam int INSTR_W = instr_w(DATA_W, SEL_W)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               instr_valid,
   output logic               instr_ready,
   input  logic [INSTR_W-1:0] instr,
   input  logic [DATA_W-1:0]  rf_a,
   input  logic [DATA_W-1:0]  rf_b,
   output logic [SEL_W-1:0]   rf_a_sel,
   output logic [SEL_W-1:0]   rf_b_sel,
   output logic [SEL_W-1:0]   rf_dest_sel,
   output logic [DATA_W-1:0]  rf_d,
   output logic               rf_load_en,
   output logic               done,
   output logic               flag_z,
   output logic               flag_c
);

   localparam int B_LSB   = b_lsb(DATA_W);
   localparam int A_LSB   = a_lsb(DATA_W, SEL_W);
   localparam int DST_LSB = dst_lsb(DATA_W, SEL_W);
   localparam int OP_LSB  = op_lsb(DATA_W, SEL_W);

   state_e              state_q, state_d;
   logic [INSTR_W-1:0]  instr_q;
   logic [DATA_W-1:0]   result_q, result_d;
   logic                flag_z_q, flag_z_d;
   logic                flag_c_q, flag_c_d;

   opcode_e             op;
   logic [DATA_W-1:0]   imm;
   logic                accept;
   logic                mul_start, mul_busy, mul_done;
   logic [2*DATA_W-1:0] mul_product;
   logic [DATA_W:0]     add_sum, sub_diff;
   logic [DATA_W-1:0]   alu_res, mul_res;
   logic                alu_c, mul_c;

   assign op        = opcode_e'(instr_q[OP_LSB +: OP_W]);
   assign imm       = instr_q[IMM_LSB +: DATA_W];
   assign accept    = instr_valid && (state_q == ST_IDLE);
   assign mul_start = (state_q == ST_EXEC) && (op == OP_MUL);

   // Selects come only from the latched instruction, which changes solely
   // on an accept in IDLE, so they hold steady from DECODE through WRITE.
   assign rf_a_sel    = instr_q[A_LSB +: SEL_W];
   assign rf_b_sel    = instr_q[B_LSB +: SEL_W];
   assign rf_dest_sel = instr_q[DST_LSB +: SEL_W];
   assign flag_z      = flag_z_q;
   assign flag_c      = flag_c_q;

   shift_add_mul #(
      .DATA_W (DATA_W)
   ) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (mul_start),
      .a_i       (rf_a),
      .b_i       (rf_b),
      .busy_o    (mul_busy),
      .done_o    (mul_done),
      .product_o (mul_product)
   );

   // Single-cycle ALU. The extra MSB of the widened add/subtract gives the
   // carry-out and the borrow (a < b) respectively.
   always_comb begin
      add_sum  = {1'b0, rf_a} + {1'b0, rf_b};
      sub_diff = {1'b0, rf_a} - {1'b0, rf_b};
      alu_res  = '0;
      alu_c    = 1'b0;
      case (op)
         OP_LDI: alu_res = imm;
         OP_ADD: begin
            alu_c = add_sum[DATA_W];
`ifdef REGFILE_CTRL_SAT_EN
            alu_res = alu_c ? '1 : add_sum[DATA_W-1:0];
`else
            alu_res = add_sum[DATA_W-1:0];
`endif
         end
         OP_SUB: begin
            alu_c = sub_diff[DATA_W];
`ifdef REGFILE_CTRL_SAT_EN
            alu_res = alu_c ? '0 : sub_diff[DATA_W-1:0];
`else
            alu_res = sub_diff[DATA_W-1:0];
`endif
         end
         OP_AND:  alu_res = rf_a & rf_b;
         OP_OR:   alu_res = rf_a | rf_b;
         OP_XOR:  alu_res = rf_a ^ rf_b;
         default: alu_res = '0;
      endcase
   end

   // Overflow of the multiply is any set bit in the upper product half.
   assign mul_c = |mul_product[2*DATA_W-1:DATA_W];
`ifdef REGFILE_CTRL_SAT_EN
   assign mul_res = mul_c ? '1 : mul_product[DATA_W-1:0];
`else
   assign mul_res = mul_product[DATA_W-1:0];
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic. The MUL fallback to IDLE only fires if the
   // multiplier stops being busy without reporting done.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (instr_valid) state_d = ST_DECODE;
         ST_DECODE: state_d = (op == OP_NOP) ? ST_IDLE : ST_EXEC;
         ST_EXEC:   state_d = (op == OP_MUL) ? ST_MUL : ST_WRITE;
         ST_MUL: begin
            if (mul_done) begin
               state_d = ST_WRITE;
            end else if (!mul_busy) begin
               state_d = ST_IDLE;
            end
         end
         ST_WRITE:  state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // FSM outputs, decoded from registered state and the latched opcode only.
   always_comb begin
      instr_ready = (state_q == ST_IDLE);
      rf_load_en  = (state_q == ST_WRITE);
      done        = (state_q == ST_WRITE) ||
                    ((state_q == ST_DECODE) && (op == OP_NOP));
      rf_d        = (state_q == ST_WRITE) ? result_q : '0;
   end

   // Instruction, result and flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q  <= '0;
         result_q <= '0;
         flag_z_q <= 1'b0;
         flag_c_q <= 1'b0;
      end else begin
         if (accept) begin
            instr_q <= instr;
         end
         result_q <= result_d;
         flag_z_q <= flag_z_d;
         flag_c_q <= flag_c_d;
      end
   end

   // Result/flag update: ALU ops and LDI commit at the end of EXEC, MUL at
   // the end of its last iteration. LDI leaves the flags untouched.
   always_comb begin
      result_d = result_q;
      flag_z_d = flag_z_q;
      flag_c_d = flag_c_q;
      if ((state_q == ST_EXEC) && (op != OP_MUL)) begin
         result_d = alu_res;
         if (op != OP_LDI) begin
            flag_z_d = (alu_res == '0);
            flag_c_d = alu_c;
         end
      end else if ((state_q == ST_MUL) && mul_done) begin
         result_d = mul_res;
         flag_z_d = (mul_res == '0);
         flag_c_d = mul_c;
      end
   end

endmodule

// File: tb/tb_regfile_exec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_exec_ctrl
// Bench for regfile_exec_ctrl with a behavioural 4x4 register file attached.
// Each instruction's expected write-back, flags and latency are computed from
// a reference copy of the registers and pushed to a scoreboard when driven,
// then popped and compared when the controller signals done.
// Build option REGFILE_CTRL_SAT_EN switches the reference to saturation.
// ---------------------------------------------------------------------------
module tb_regfile_exec_ctrl;
   import regfile_ctrl_pkg::*;

   localparam int DW = 4;
   localparam int SW = 2;
   localparam int IW = 13;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          instr_valid;
   logic          instr_ready;
   logic [IW-1:0] instr;
   logic [DW-1:0] rf_a, rf_b;
   logic [SW-1:0] rf_a_sel, rf_b_sel, rf_dest_sel;
   logic [DW-1:0] rf_d;
   logic          rf_load_en;
   logic          done;
   logic          flag_z, flag_c;

   typedef struct {
      logic [SW-1:0] dst;
      logic [DW-1:0] data;
      logic          wr;
      logic          z;
      logic          c;
      int            lat;
   } exp_t;

   exp_t          scoreboard[$];
   logic [DW-1:0] refRegs [4];
   logic          refZ, refC;
   logic [DW-1:0] rfMem [4];
   logic          rfClear;
   int            nChecks = 0;
   int            nFail = 0;
   int            nAccepts = 0;
   int            cyc = 0;
   int            lastAcceptCyc = 0;
   int            acceptCyc;

   regfile_exec_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .rf_a        (rf_a),
      .rf_b        (rf_b),
      .rf_a_sel    (rf_a_sel),
      .rf_b_sel    (rf_b_sel),
      .rf_dest_sel (rf_dest_sel),
      .rf_d        (rf_d),
      .rf_load_en  (rf_load_en),
      .done        (done),
      .flag_z      (flag_z),
      .flag_c      (flag_c)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Register file the controller drives: combinational reads, write on edge.
   always @(posedge clk) begin
      if (rfClear) begin
         for (int i = 0; i < 4; i++) rfMem[i] <= '0;
      end else if (rf_load_en) begin
         rfMem[rf_dest_sel] <= rf_d;
      end
   end
   assign rf_a = rfMem[rf_a_sel];
   assign rf_b = rfMem[rf_b_sel];

   // Handshake monitor: counts transfers and remembers when the last one was.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n && instr_valid && instr_ready) begin
         nAccepts      <= nAccepts + 1;
         lastAcceptCyc <= cyc;
      end
   end

   // Hard stop in case something wedges outside the bounded waits.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkVal(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compute the expected outcome, queue it, and offer the instruction.
   task automatic applyStimulus(input logic [2:0] op, input logic [1:0] dst,
                                input logic [1:0] a, input logic [1:0] b,
                                input logic [3:0] imm);
      exp_t e;
      int   av, bv, r;
      logic c;
      av = int'(refRegs[a]);
      bv = int'(refRegs[b]);
      r  = 0;
      c  = 1'b0;
      e.dst = dst;
      e.wr  = 1'b1;
      e.z   = refZ;
      e.c   = refC;
      e.lat = 3;
      case (op)
         3'd0: begin e.wr = 1'b0; e.lat = 1; end
         3'd1: r = int'(imm);
         3'd2: begin r = av + bv; c = (r > 15); end
         3'd3: begin r = av - bv; c = (av < bv); end
         3'd4: r = av & bv;
         3'd5: r = av | bv;
         3'd6: r = av ^ bv;
         default: begin r = av * bv; c = (r > 15); e.lat = 7; end
      endcase
      if (op >= 3'd2) begin
`ifdef REGFILE_CTRL_SAT_EN
         if (c) r = (op == 3'd3) ? 0 : 15;
`endif
         r   = r & 15;
         e.z = (r == 0);
         e.c = c;
      end
      e.data = 4'(r);
      scoreboard.push_back(e);
      instr       = {op, dst, a, b, imm};
      instr_valid = 1'b1;
   endtask

   // Pop the oldest expectation and compare against what the DUT shows in
   // its done cycle; optionally pulse reset in that cycle instead.
   task automatic checkOutput(input int lat, input int readyHigh,
                              input bit resetInWrite);
      exp_t e;
      if (scoreboard.size() == 0) begin
         checkVal("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = scoreboard.pop_front();
      checkVal("latency", lat, e.lat);
      checkVal("ready_low_while_busy", readyHigh, 0);
      checkVal("load_en", rf_load_en, e.wr);
      if (e.wr) begin
         checkVal("dest_sel", rf_dest_sel, e.dst);
         checkVal("rf_d", rf_d, e.data);
      end
      if (resetInWrite) begin
         rst_n = 1'b0;
         #1;
         checkVal("rst_load_en", rf_load_en, 1'b0);
         checkVal("rst_done", done, 1'b0);
         checkVal("rst_ready", instr_ready, 1'b1);
         checkVal("rst_flag_z", flag_z, 1'b0);
         checkVal("rst_flag_c", flag_c, 1'b0);
         refZ = 1'b0;
         refC = 1'b0;
         @(posedge clk);
         @(negedge clk);
         rst_n = 1'b1;
      end else begin
         checkVal("flag_z", flag_z, e.z);
         checkVal("flag_c", flag_c, e.c);
         refZ = e.z;
         refC = e.c;
         if (e.wr) refRegs[e.dst] = e.data;
      end
   endtask

   // Drive one instruction from a negedge, wait for its transfer and done,
   // then check it. keepValid leaves instr_valid high for a follow-on.
   task automatic runInstr(input logic [2:0] op, input logic [1:0] dst,
                           input logic [1:0] a, input logic [1:0] b,
                           input logic [3:0] imm, input bit keepValid,
                           input bit resetInWrite);
      int guard, lat, readyHigh;
      applyStimulus(op, dst, a, b, imm);
      guard = 0;
      while (instr_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      checkVal("accept_wait", guard < 50, 1'b1);
      @(posedge clk);
      lat       = 0;
      readyHigh = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 1) begin
            acceptCyc = lastAcceptCyc;
            if (!keepValid) instr_valid = 1'b0;
         end
         if (instr_ready === 1'b1) readyHigh++;
      end while (done !== 1'b1 && lat < 20);
      checkOutput(lat, readyHigh, resetInWrite);
   endtask

   // Let the last write land, then compare the whole register file.
   task automatic checkRegs();
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         checkVal($sformatf("reg%0d", i), rfMem[i], refRegs[i]);
      end
   endtask

   initial begin
      int a1, accBefore;
      rst_n       = 1'b0;
      rfClear     = 1'b1;
      instr_valid = 1'b0;
      instr       = '0;
      refZ        = 1'b0;
      refC        = 1'b0;
      for (int i = 0; i < 4; i++) refRegs[i] = '0;

      // Reset state.
      @(negedge clk);
      checkVal("reset_ready", instr_ready, 1'b1);
      checkVal("reset_load_en", rf_load_en, 1'b0);
      checkVal("reset_done", done, 1'b0);
      checkVal("reset_flag_z", flag_z, 1'b0);
      checkVal("reset_flag_c", flag_c, 1'b0);
      checkVal("reset_rf_d", rf_d, 4'h0);
      checkVal("reset_sels", {rf_a_sel, rf_b_sel, rf_dest_sel}, 6'd0);
      @(negedge clk);
      rst_n   = 1'b1;
      rfClear = 1'b0;
      $display("[TB] reset released");

      // LDI r1=9, LDI r2=8, ADD r3=r1+r2 (carry out).
      runInstr(OP_LDI, 2'd1, 2'd0, 2'd0, 4'h9, 1'b0, 1'b0);
      runInstr(OP_LDI, 2'd2, 2'd0, 2'd0, 4'h8, 1'b0, 1'b0);
      runInstr(OP_ADD, 2'd3, 2'd1, 2'd2, 4'h0, 1'b0, 1'b0);
      checkRegs();

      // SUB r0=r2-r1 (borrow).
      runInstr(OP_SUB, 2'd0, 2'd2, 2'd1, 4'h0, 1'b0, 1'b0);
      checkRegs();

      // MUL without and with upper-half overflow.
      runInstr(OP_LDI, 2'd1, 2'd0, 2'd0, 4'h3, 1'b0, 1'b0);
      runInstr(OP_LDI, 2'd2, 2'd0, 2'd0, 4'h5, 1'b0, 1'b0);
      runInstr(OP_MUL, 2'd3, 2'd1, 2'd2, 4'h0, 1'b0, 1'b0);
      runInstr(OP_LDI, 2'd1, 2'd0, 2'd0, 4'h6, 1'b0, 1'b0);
      runInstr(OP_LDI, 2'd2, 2'd0, 2'd0, 4'h6, 1'b0, 1'b0);
      runInstr(OP_MUL, 2'd3, 2'd1, 2'd2, 4'h0, 1'b0, 1'b0);
      checkRegs();

      // Back-to-back ADDs with instr_valid held high throughout.
      accBefore = nAccepts;
      runInstr(OP_ADD, 2'd0, 2'd1, 2'd2, 4'h0, 1'b1, 1'b0);
      a1 = acceptCyc;
      runInstr(OP_ADD, 2'd3, 2'd0, 2'd1, 4'h0, 1'b1, 1'b0);
      checkVal("b2b_spacing_1", acceptCyc - a1, 4);
      a1 = acceptCyc;
      runInstr(OP_ADD, 2'd2, 2'd2, 2'd2, 4'h0, 1'b0, 1'b0);
      checkVal("b2b_spacing_2", acceptCyc - a1, 4);
      checkRegs();
      checkVal("b2b_accept_count", nAccepts - accBefore, 3);

      // Reset pulsed during the MUL write-back cycle: no write happens.
      runInstr(OP_LDI, 2'd1, 2'd0, 2'd0, 4'h7, 1'b0, 1'b0);
      runInstr(OP_LDI, 2'd2, 2'd0, 2'd0, 4'h3, 1'b0, 1'b0);
      runInstr(OP_MUL, 2'd0, 2'd1, 2'd2, 4'h0, 1'b0, 1'b1);
      checkVal("post_rst_ready", instr_ready, 1'b1);
      checkRegs();

      // XOR of a register with itself into itself, then NOP.
      runInstr(OP_XOR, 2'd1, 2'd1, 2'd1, 4'h0, 1'b0, 1'b0);
      runInstr(OP_NOP, 2'd2, 2'd3, 2'd0, 4'hA, 1'b0, 1'b0);
      checkRegs();

      $display("End of test - %0d assertions evaluated, %0d failures",
               nChecks, nFail);
      $finish;
   end

endmodule
